// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the rv_fetch instruction fetch stage
package rv_fetch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } fetch_entry_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/rv_fetch_fifo.sv
// rtl/rv_fetch_fifo.sv - synchronous instruction buffer with flush and simultaneous push/pop
module rv_fetch_fifo
   import rv_fetch_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  entry_t                     push_data,
   input  logic                       pop,
   output entry_t                     head,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;

   assign head  = mem[rd_ptr];
   assign valid = (count != '0);

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         assert (!(push && !pop && count == CW'(DEPTH)));
         assert (!(pop && count == '0));
      end
   end

endmodule

// File: rtl/rv_fetch.sv
// rtl/rv_fetch.sv - instruction fetch stage: PC, ICCM request issue, buffered handoff to decode
// Optional misaligned-redirect fault entry enabled by defining RV_FETCH_MISALIGN_EN.
module rv_fetch
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_en_o,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        instr_err_o
);

   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic [31:0]   fetch_pc;
   logic [31:0]   last_addr;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic          inflight_err;
   logic          halted;
   logic [31:0]   target_pc;
   logic          target_bad;
   logic [CW-1:0] count;
   logic [CW:0]   occ;
   logic          pop;
   logic          push;
   logic          issue;
   fetch_entry_t  push_data;
   fetch_entry_t  head;

`ifdef RV_FETCH_MISALIGN_EN
   assign target_pc  = redirect_pc_i;
   assign target_bad = (redirect_pc_i[1:0] != 2'b00);
`else
   assign target_pc  = redirect_pc_i & 32'hFFFF_FFFC;
   assign target_bad = 1'b0;
`endif

   assign pop   = instr_valid_o & instr_ready_i & ~redirect_i;
   assign push  = inflight & ~redirect_i;
   // Occupancy counts the outstanding request so the buffer can always absorb it.
   assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
   assign issue = ~rst_i & ~redirect_i & ~halted & (occ < (CW+1)'(FIFO_DEPTH));

   assign imem_en_o   = issue;
   assign imem_addr_o = issue ? fetch_pc : last_addr;

   // A faulting redirect reuses the inflight slot to emit its single NOP entry.
   assign push_data.pc    = inflight_pc;
   assign push_data.instr = inflight_err ? NOP_INSTR : imem_rdata_i;
   assign push_data.err   = inflight_err;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc     <= RESET_PC;
         last_addr    <= RESET_PC;
         inflight     <= 1'b0;
         inflight_pc  <= RESET_PC;
         inflight_err <= 1'b0;
         halted       <= 1'b0;
      end else if (redirect_i) begin
         fetch_pc     <= target_pc;
         inflight     <= target_bad;
         inflight_pc  <= target_pc;
         inflight_err <= target_bad;
         halted       <= target_bad;
      end else begin
         inflight     <= issue;
         inflight_err <= 1'b0;
         if (issue) begin
            fetch_pc    <= fetch_pc + 32'd4;
            last_addr   <= fetch_pc;
            inflight_pc <= fetch_pc;
         end
      end
   end

   rv_fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .flush     (redirect_i),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .valid     (instr_valid_o),
      .count     (count)
   );

   assign instr_o     = head.instr;
   assign pc_o        = head.pc;
   assign instr_err_o = head.err;

endmodule
